// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state type,
// the NOP encoding used for IF/ID bubbles and the sequential PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request outstanding or about to be issued
    ST_HOLD = 2'd1,  // fetched word parked in the skid buffer during a stall
    ST_DROP = 2'd2   // redirect seen mid-transfer; discard the word in flight
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/sat_counter.sv
// 16-bit saturating event counter with asynchronous active-low reset.
// The whole module is built only when FETCH_PERF_EN is defined, so the
// default build carries no stray top-level module.
`ifdef FETCH_PERF_EN
module sat_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] count_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Increment on each enabled cycle, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory request, tracks the
// PC, parks a fetched word in a one-entry skid buffer while decode stalls,
// discards words made stale by a redirect, and owns the IF/ID register.
// Optional macro FETCH_PERF_EN adds bubble_cnt / redirect_cnt counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_W     = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               PcSrcE,
  input  logic [PC_W-1:0]    PcTargetE,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        redirect_cnt
`endif
);

  localparam logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR);
  localparam logic [PC_W-1:0]    PC_STEP = PC_W'(PC_INC);

  fetch_state_e        state_q, state_d;
  logic                req_q, req_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  skid_q, skid_d;
  logic [PC_W-1:0]     pend_q, pend_d;

  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_W-1:0]     pcd_q, pcd_d;
  logic [PC_W-1:0]     pcp4_q, pcp4_d;
  logic                valid_q, valid_d;

  logic                xfer_done;
  logic                load;
  logic [INSTR_W-1:0]  load_instr;
  logic                bubble_evt;

  assign xfer_done = req_q & imem_ready;

  // Fetch FSM next state: PC, skid buffer, pending redirect target and
  // whether IF/ID should accept a new instruction this cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    pend_d     = pend_q;
    load       = 1'b0;
    load_instr = imem_rdata;
    case (state_q)
      ST_REQ: begin
        if (xfer_done) begin
          if (PcSrcE) begin
            pc_d = PcTargetE;
          end else if (StallF | StallD) begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            load = 1'b1;
            pc_d = pc_q + PC_STEP;
          end
        end else if (PcSrcE) begin
          pend_d  = PcTargetE;
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (PcSrcE) begin
          pc_d    = PcTargetE;
          state_d = ST_REQ;
        end else if (!StallD) begin
          load       = 1'b1;
          load_instr = skid_q;
          pc_d       = pc_q + PC_STEP;
          state_d    = ST_REQ;
        end
      end
      ST_DROP: begin
        // Address must stay put until the stale transfer completes; a
        // redirect arriving in the completing cycle is the newest target.
        if (xfer_done) begin
          pc_d    = PcSrcE ? PcTargetE : pend_q;
          state_d = ST_REQ;
        end else if (PcSrcE) begin
          pend_d = PcTargetE;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
    req_d = (state_d != ST_HOLD);
  end

  // IF/ID next value with priority flush > stall > load > bubble.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pcd_d      = pcd_q;
    pcp4_d     = pcp4_q;
    bubble_evt = 1'b0;
    if (FlushD) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (StallD) begin
      valid_d = valid_q;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pcd_d   = pc_q;
      pcp4_d  = pc_q + PC_STEP;
    end else begin
      valid_d    = 1'b0;
      instr_d    = NOP;
      bubble_evt = 1'b1;
    end
  end

  // Fetch FSM state, registered request strobe, PC and side buffers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_REQ;
      req_q   <= 1'b1;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      pend_q  <= pend_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pcd_q   <= '0;
      pcp4_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign ValidD    = valid_q;

`ifdef FETCH_PERF_EN
  sat_counter u_bubble_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (bubble_evt),
    .count_o (bubble_cnt)
  );

  sat_counter u_redirect_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (PcSrcE),
    .count_o (redirect_cnt)
  );
`else
  logic unused_bubble;
  assign unused_bubble = bubble_evt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table for the
// hand-built corner cases, then randomized traffic against a reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PcSrcE = 1'b0;
  logic [31:0] PcTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_EN
  logic [15:0] bubble_cnt, redirect_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0001;
  endfunction

  assign imem_rdata = mem(imem_addr);

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PcSrcE     (PcSrcE),
    .PcTargetE  (PcTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
`ifdef FETCH_PERF_EN
    ,
    .bubble_cnt   (bubble_cnt),
    .redirect_cnt (redirect_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_buf, m_pend, m_instr, m_pcd, m_p4;
  logic        m_buf_full, m_drop, m_vld;
  int          m_bub, m_red;

  task automatic model_reset();
    m_pc = 32'h0; m_buf = '0; m_pend = '0; m_buf_full = 1'b0; m_drop = 1'b0;
    m_vld = 1'b0; m_instr = NOP_W; m_pcd = '0; m_p4 = '0; m_bub = 0; m_red = 0;
  endtask

  task automatic model_step(input logic rdy, input logic sf, input logic sd,
                            input logic fl, input logic br, input logic [31:0] tgt);
    logic        got, take;
    logic [31:0] word, at;
    take = 1'b0; word = '0; at = m_pc;
    got  = !m_buf_full && rdy;
    if (m_buf_full) begin
      if (br) begin
        m_buf_full = 1'b0; m_pc = tgt;
      end else if (!sd) begin
        take = 1'b1; word = m_buf; m_buf_full = 1'b0; m_pc = m_pc + 32'd4;
      end
    end else if (m_drop) begin
      if (got) begin
        m_drop = 1'b0; m_pc = br ? tgt : m_pend;
      end else if (br) begin
        m_pend = tgt;
      end
    end else if (got) begin
      if (br) m_pc = tgt;
      else if (sf || sd) begin
        m_buf = mem(m_pc); m_buf_full = 1'b1;
      end else begin
        take = 1'b1; word = mem(m_pc); m_pc = m_pc + 32'd4;
      end
    end else if (br) begin
      m_drop = 1'b1; m_pend = tgt;
    end
    if (fl) begin
      m_vld = 1'b0; m_instr = NOP_W;
    end else if (sd) begin
      m_vld = m_vld;
    end else if (take) begin
      m_vld = 1'b1; m_instr = word; m_pcd = at; m_p4 = at + 32'd4;
    end else begin
      m_vld = 1'b0; m_instr = NOP_W;
      if (m_bub < 65535) m_bub++;
    end
    if (br && m_red < 65535) m_red++;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rdy, sf, sd, fl, br;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pcd, exp_p4, exp_instr;
    int          exp_bub, exp_red;
  } vec_t;

  vec_t tbl[22];

  task automatic set_inputs(input logic rdy, input logic sf, input logic sd,
                            input logic fl, input logic br, input logic [31:0] tgt);
    imem_ready = rdy; StallF = sf; StallD = sd; FlushD = fl; PcSrcE = br; PcTargetE = tgt;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst ValidD", {31'b0, ValidD}, 32'h0);
    chk("rst InstrD", InstrD, NOP_W);
    chk("rst PCD", PCD, 32'h0);
    chk("rst PCPlus4D", PCPlus4D, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst imem_req", {31'b0, imem_req}, 32'h1);
`ifdef FETCH_PERF_EN
    chk("rst bubble_cnt", {16'b0, bubble_cnt}, 32'h0);
    chk("rst redirect_cnt", {16'b0, redirect_cnt}, 32'h0);
`endif
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0,0,32'h0,        1,32'h0,        1,32'h0,        32'h4,  mem(32'h0),  0,0};
    tbl[1]  = '{1,0,0,0,0,32'h0,        1,32'h4,        1,32'h4,        32'h8,  mem(32'h4),  0,0};
    tbl[2]  = '{0,0,0,0,0,32'h0,        1,32'h8,        0,32'h4,        32'h8,  NOP_W,       1,0};
    tbl[3]  = '{0,0,0,0,0,32'h0,        1,32'h8,        0,32'h4,        32'h8,  NOP_W,       2,0};
    tbl[4]  = '{0,0,0,0,0,32'h0,        1,32'h8,        0,32'h4,        32'h8,  NOP_W,       3,0};
    tbl[5]  = '{1,0,0,0,0,32'h0,        1,32'h8,        1,32'h8,        32'hC,  mem(32'h8),  3,0};
    tbl[6]  = '{1,1,1,0,0,32'h0,        1,32'hC,        1,32'h8,        32'hC,  mem(32'h8),  3,0};
    tbl[7]  = '{1,1,1,0,0,32'h0,        0,32'hC,        1,32'h8,        32'hC,  mem(32'h8),  3,0};
    tbl[8]  = '{0,0,0,0,0,32'h0,        0,32'hC,        1,32'hC,        32'h10, mem(32'hC),  3,0};
    tbl[9]  = '{1,0,0,0,0,32'h0,        1,32'h10,       1,32'h10,       32'h14, mem(32'h10), 3,0};
    tbl[10] = '{0,0,0,0,1,32'h40,       1,32'h14,       0,32'h10,       32'h14, NOP_W,       4,1};
    tbl[11] = '{0,0,0,0,0,32'h0,        1,32'h14,       0,32'h10,       32'h14, NOP_W,       5,1};
    tbl[12] = '{1,0,0,0,0,32'h0,        1,32'h14,       0,32'h10,       32'h14, NOP_W,       6,1};
    tbl[13] = '{1,0,0,0,0,32'h0,        1,32'h40,       1,32'h40,       32'h44, mem(32'h40), 6,1};
    tbl[14] = '{1,1,1,0,0,32'h0,        1,32'h44,       1,32'h40,       32'h44, mem(32'h40), 6,1};
    tbl[15] = '{1,1,1,1,1,32'h80,       0,32'h44,       0,32'h40,       32'h44, NOP_W,       6,2};
    tbl[16] = '{1,0,0,0,0,32'h0,        1,32'h80,       1,32'h80,       32'h84, mem(32'h80), 6,2};
    tbl[17] = '{1,0,0,0,1,32'h100,      1,32'h84,       0,32'h80,       32'h84, NOP_W,       7,3};
    tbl[18] = '{1,0,0,0,0,32'h0,        1,32'h100,      1,32'h100,      32'h104,mem(32'h100),7,3};
    tbl[19] = '{1,0,0,0,1,32'hFFFFFFFC, 1,32'h104,      0,32'h100,      32'h104,NOP_W,       8,4};
    tbl[20] = '{1,0,0,0,0,32'h0,        1,32'hFFFFFFFC, 1,32'hFFFFFFFC, 32'h0,  mem(32'hFFFFFFFC),8,4};
    tbl[21] = '{1,0,0,0,0,32'h0,        1,32'h0,        1,32'h0,        32'h4,  mem(32'h0),  8,4};

    do_reset();

    for (int i = 0; i < 22; i++) begin
      set_inputs(tbl[i].rdy, tbl[i].sf, tbl[i].sd, tbl[i].fl, tbl[i].br, tbl[i].tgt);
      #1;
      chk($sformatf("vec%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
      chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].exp_addr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d ValidD", i), {31'b0, ValidD}, {31'b0, tbl[i].exp_vld});
      chk($sformatf("vec%0d PCD", i), PCD, tbl[i].exp_pcd);
      chk($sformatf("vec%0d PCPlus4D", i), PCPlus4D, tbl[i].exp_p4);
      chk($sformatf("vec%0d InstrD", i), InstrD, tbl[i].exp_instr);
`ifdef FETCH_PERF_EN
      chk($sformatf("vec%0d bubble_cnt", i), {16'b0, bubble_cnt}, tbl[i].exp_bub);
      chk($sformatf("vec%0d redirect_cnt", i), {16'b0, redirect_cnt}, tbl[i].exp_red);
`endif
    end

    // ---------------- randomized traffic ----------------
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        r, sf, sd, fl, br;
      logic [31:0] t;
      r  = ($urandom_range(0, 9) < 7);
      sf = ($urandom_range(0, 19) < 3);
      sd = ($urandom_range(0, 19) < 3);
      fl = ($urandom_range(0, 9) == 0);
      br = ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                       : ($urandom & 32'hFFFF_FFFC);
      set_inputs(r, sf, sd, fl, br, t);
      #1;
      chk($sformatf("rnd%0d imem_req", c), {31'b0, imem_req}, {31'b0, !m_buf_full});
      chk($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);
      model_step(r, sf, sd, fl, br, t);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d ValidD", c), {31'b0, ValidD}, {31'b0, m_vld});
      chk($sformatf("rnd%0d InstrD", c), InstrD, m_instr);
      chk($sformatf("rnd%0d PCD", c), PCD, m_pcd);
      chk($sformatf("rnd%0d PCPlus4D", c), PCPlus4D, m_p4);
`ifdef FETCH_PERF_EN
      chk($sformatf("rnd%0d bubble_cnt", c), {16'b0, bubble_cnt}, m_bub);
      chk($sformatf("rnd%0d redirect_cnt", c), {16'b0, redirect_cnt}, m_red);
`endif
    end

    // ---------------- reset in the middle of a transfer ----------------
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst imem_addr", imem_addr, 32'h0);
    chk("midrst imem_req", {31'b0, imem_req}, 32'h1);
    chk("midrst ValidD", {31'b0, ValidD}, 32'h0);
    chk("midrst InstrD", InstrD, NOP_W);
    chk("midrst PCD", PCD, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("postrst imem_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    chk("postrst ValidD", {31'b0, ValidD}, 32'h1);
    chk("postrst PCD", PCD, 32'h0);
    chk("postrst InstrD", InstrD, mem(32'h0));
    chk("postrst imem_addr next", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_W, default 32, SHALL set the program-counter width.
REQ-002 Parameter INSTR_W, default 32, SHALL set the instruction width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-004 Port clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-low.
REQ-006 Ports StallF, StallD, FlushD, PcSrcE  in  1 each: hazard/branch controls from the hazard unit and execute stage.
REQ-007 Port PcTargetE  in  PC_W: branch/jump target, valid when PcSrcE=1.
REQ-008 Ports imem_req  out  1 and imem_addr  out  PC_W: instruction-memory request and address.
REQ-009 Ports imem_ready  in  1 and imem_rdata  in  INSTR_W: the transfer completes in the cycle where imem_req=1 and imem_ready=1; imem_rdata is valid only in that cycle.
REQ-010 Ports InstrD  out  INSTR_W, PCD  out  PC_W, PCPlus4D  out  PC_W, ValidD  out  1: the IF/ID register contents.

Function
REQ-011 The FSM SHALL have exactly three states: REQ, HOLD, DROP.
REQ-012 In REQ and DROP, imem_req SHALL be 1; in HOLD it SHALL be 0.
REQ-013 While imem_req=1 and imem_ready=0, imem_addr SHALL stay stable.
REQ-014 REQ, on completion with PcSrcE=1: the data SHALL be discarded, PC<=PcTargetE, and the state SHALL stay REQ.
REQ-015 REQ, on completion with PcSrcE=0 and (StallF|StallD)=1: imem_rdata SHALL be captured into a one-entry skid buffer, the PC SHALL be held, and the state SHALL go to HOLD.
REQ-016 REQ, on completion with no stall and no redirect: IF/ID SHALL load {imem_rdata, PC, PC+4} with ValidD=1, and PC<=PC+4.
REQ-017 REQ, with no completion and PcSrcE=1: PcTargetE SHALL be stored in a pending-target register and the state SHALL go to DROP.
REQ-018 DROP, on completion: the data SHALL be discarded, PC<=pending target, and the state SHALL go to REQ.
REQ-019 DROP, on a further PcSrcE=1: the pending target SHALL be overwritten.
REQ-020 HOLD, with PcSrcE=1: the buffer SHALL be discarded, PC<=PcTargetE, and the state SHALL go to REQ.
REQ-021 HOLD, with StallD=0: IF/ID SHALL load from the buffer with ValidD=1, PC<=PC+4, and the state SHALL go to REQ.
REQ-022 IF/ID priority SHALL be FlushD > StallD > load > bubble.
REQ-023 FlushD: ValidD<=0 and InstrD<=NOP (0x00000013).
REQ-024 StallD without FlushD: IF/ID SHALL hold its value.
REQ-025 When no flush, no stall and no load occur: ValidD<=0 and InstrD<=NOP.
REQ-026 PC arithmetic SHALL be modulo 2^PC_W; PC+4 SHALL wrap silently.

Reset
REQ-027 While rst=0: state=REQ, PC=RESET_PC, ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=0, skid buffer and pending target cleared, counters 0.
REQ-028 A reset asserted mid-transfer SHALL abandon the transfer; the first request after release SHALL be to RESET_PC.

Configuration
REQ-029 With macro FETCH_PERF_EN defined: ports bubble_cnt out 16 and redirect_cnt out 16 SHALL exist; bubble_cnt counts cycles that load a REQ-025 bubble; redirect_cnt counts cycles with PcSrcE=1; both saturate at 0xFFFF.
REQ-030 Without FETCH_PERF_EN: those ports and counters SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the FSM state type, the NOP constant and the PC increment constant (4).
REQ-032 Sub-module sat_counter (16-bit, saturating, async active-low reset) SHALL be instantiated twice, only under FETCH_PERF_EN.

Verification
REQ-033 Reset release, imem_ready held 1: imem_addr 0,4,8 on consecutive cycles; ValidD=1 with PCD 0,4 one cycle later.
REQ-034 imem_ready low 3 cycles at addr 0x8: addr stays 0x8; three bubbles (ValidD=0, InstrD=0x00000013); bubble_cnt=3 when enabled.
REQ-035 StallD=StallF=1 on completion at 0xC: state HOLD, imem_req=0, IF/ID unchanged; after stall drops, InstrD=rdata(0xC), PCD=0xC, next imem_addr 0x10.
REQ-036 PcSrcE=1, PcTargetE=0x40 while ready=0 at 0x14: addr stays 0x14 until ready; that data is dropped; next imem_addr 0x40; ValidD=0 throughout.
REQ-037 PcSrcE with FlushD=StallD=1 in HOLD: buffer dropped; ValidD=0; next imem_addr = target.
REQ-038 PC=0xFFFFFFFC completes: PCPlus4D=0, next imem_addr 0.
